// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency meter.
// Holds the measurement FSM state encoding and the default counter width
// and synchroniser depth used by frequency_meter and edge_sync.
package freq_meter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH       = 16;
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/edge_sync.sv
// Synchroniser and rising-edge detector for an asynchronous input.
// Ports:
//   Clock    - sole clock, rising edge
//   Clear    - synchronous active-low reset
//   Sig_In   - asynchronous input signal
//   Sync_Out - synchronised level, aligned with Rise
//   Rise     - one-cycle pulse marking a 0->1 transition of the synchronised level
module edge_sync
  import freq_meter_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic Clock,
  input  logic Clear,
  input  logic Sig_In,
  output logic Sync_Out,
  output logic Rise
);

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   hist;

  // The rise decision is registered, so Rise appears one cycle after the
  // synchronised level changes. The history flop holds exactly that earlier
  // level, so presenting it as Sync_Out keeps level and Rise on the same cycle.
  always_ff @(posedge Clock) begin
    if (!Clear) begin
      sync_chain <= '0;
      hist       <= 1'b0;
      Rise       <= 1'b0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], Sig_In};
      hist       <= sync_chain[SYNC_STAGES-1];
      Rise       <= sync_chain[SYNC_STAGES-1] & ~hist;
    end
  end

  assign Sync_Out = hist;

endmodule

// File: rtl/frequency_meter.sv
// Period and high-time meter for a slow signal sampled by Clock.
// Ports:
//   Clock        - sole clock, rising edge
//   Clear        - synchronous active-low reset
//   Enable       - high runs the meter, low returns it to idle and clears Overflow
//   Sig_In       - measured signal, may be asynchronous to Clock
//   Period       - Clock cycles between the last two detected rises
//   High_Time    - Clock cycles Sig_In was high within that period
//   Period_Valid - one-cycle pulse when Period/High_Time are updated
//   Overflow     - sticky flag, a period ran past the counter range
module frequency_meter
  import freq_meter_pkg::*;
#(
  parameter int WIDTH       = DEFAULT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             Clock,
  input  logic             Clear,
  input  logic             Enable,
  input  logic             Sig_In,
  output logic [WIDTH-1:0] Period,
  output logic [WIDTH-1:0] High_Time,
  output logic             Period_Valid,
  output logic             Overflow
);

  // Highest value the period counter may hold; a rise here still reports
  // 2^WIDTH-1, anything longer is an overflow, so the counter never wraps.
  localparam logic [WIDTH-1:0] CNT_LIMIT = {{(WIDTH-1){1'b1}}, 1'b0};
  localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t           state;
  logic [WIDTH-1:0] per_cnt;
  logic [WIDTH-1:0] high_cnt;
  logic             sync_lvl;
  logic             rise;

  function automatic logic [WIDTH-1:0] add_bit(input logic [WIDTH-1:0] val,
                                               input logic              b);
    return val + {{(WIDTH-1){1'b0}}, b};
  endfunction

  edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .Clock   (Clock),
    .Clear   (Clear),
    .Sig_In  (Sig_In),
    .Sync_Out(sync_lvl),
    .Rise    (rise)
  );

  always_ff @(posedge Clock) begin
    if (!Clear) begin
      state        <= IDLE;
      per_cnt      <= '0;
      high_cnt     <= '0;
      Period       <= '0;
      High_Time    <= '0;
      Period_Valid <= 1'b0;
      Overflow     <= 1'b0;
    end else begin
      Period_Valid <= 1'b0;
      if (!Enable) begin
        // Abort any partial measurement.
        state    <= IDLE;
        Overflow <= 1'b0;
        per_cnt  <= '0;
        high_cnt <= '0;
      end else begin
        case (state)
          IDLE: state <= ARM;
          ARM: begin
            // First rise only starts the count; there is no earlier edge to
            // measure from, so nothing is reported.
            if (rise) begin
              state    <= MEASURE;
              per_cnt  <= '0;
              high_cnt <= CNT_ONE;
            end
          end
          MEASURE: begin
            if (rise) begin
              Period       <= per_cnt + CNT_ONE;
              High_Time    <= high_cnt;
              Period_Valid <= 1'b1;
              per_cnt      <= '0;
              high_cnt     <= CNT_ONE;
            end else if (per_cnt == CNT_LIMIT) begin
              Overflow <= 1'b1;
              state    <= ARM;
            end else begin
              per_cnt  <= per_cnt + CNT_ONE;
              high_cnt <= add_bit(high_cnt, sync_lvl);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frequency_meter.sv
// Self-checking bench for frequency_meter: a 16-bit instance for the main
// measurements and a 4-bit instance for the overflow corner cases.
module tb_frequency_meter;

  localparam int SYNC = 2;

  typedef struct {
    int period;
    int high;
    int cyc;
  } exp_t;

  typedef struct {
    int hi;
    int lo;
    int exp_period;
    int exp_high;
  } vec_t;

  logic        clk = 1'b0;
  logic        clear;
  logic        enable16, enable4;
  logic        sig16, sig4;
  logic [15:0] period16, high16;
  logic        valid16, ovf16;
  logic [3:0]  period4, high4;
  logic        valid4, ovf4;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q16[$];
  exp_t q4[$];
  bit   have16, have4;
  int   prev16_p, prev16_h, prev4_p, prev4_h;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frequency_meter #(.WIDTH(16), .SYNC_STAGES(SYNC)) dut16 (
    .Clock(clk), .Clear(clear), .Enable(enable16), .Sig_In(sig16),
    .Period(period16), .High_Time(high16), .Period_Valid(valid16), .Overflow(ovf16)
  );

  frequency_meter #(.WIDTH(4), .SYNC_STAGES(SYNC)) dut4 (
    .Clock(clk), .Clear(clear), .Enable(enable4), .Sig_In(sig4),
    .Period(period4), .High_Time(high4), .Period_Valid(valid4), .Overflow(ovf4)
  );

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A rise driven now is reported SYNC+2 edges later.
  task automatic rise16();
    exp_t e;
    if (have16) begin
      e.period = prev16_p; e.high = prev16_h; e.cyc = cyc + SYNC + 2;
      q16.push_back(e);
    end
    sig16 = 1'b1;
  endtask

  task automatic rise4();
    exp_t e;
    if (have4) begin
      e.period = prev4_p; e.high = prev4_h; e.cyc = cyc + SYNC + 2;
      q4.push_back(e);
    end
    sig4 = 1'b1;
  endtask

  task automatic seg16(input int hi, input int lo, input int p, input int h);
    rise16();
    repeat (hi) tick();
    sig16 = 1'b0;
    repeat (lo) tick();
    have16 = 1'b1; prev16_p = p; prev16_h = h;
  endtask

  task automatic seg4(input int hi, input int lo, input int p, input int h);
    rise4();
    repeat (hi) tick();
    sig4 = 1'b0;
    repeat (lo) tick();
    have4 = 1'b1; prev4_p = p; prev4_h = h;
  endtask

  initial begin
    vec_t vecs[16];
    int   c0;

    vecs = '{'{1,1,2,1}, '{1,1,2,1}, '{1,1,2,1}, '{1,1,2,1}, '{1,1,2,1}, '{1,1,2,1},
             '{4,12,16,4}, '{4,12,16,4}, '{4,12,16,4},
             '{7,1,8,7}, '{7,1,8,7}, '{7,1,8,7},
             '{3,5,8,3}, '{10,2,12,10}, '{1,9,10,1}, '{5,5,10,5}};

    clear = 1'b0; enable16 = 1'b0; enable4 = 1'b0; sig16 = 1'b0; sig4 = 1'b0;
    have16 = 1'b0; have4 = 1'b0;
    prev16_p = 0; prev16_h = 0; prev4_p = 0; prev4_h = 0;

    fork
      begin
        exp_t e;
        forever begin
          @(negedge clk);
          if (valid16) begin
            if (q16.size() == 0) chk("unexpected_valid16", 1, 0);
            else begin
              e = q16.pop_front();
              chk("period16", int'(period16), e.period);
              chk("high16", int'(high16), e.high);
              chk("valid_cycle16", cyc, e.cyc);
            end
          end
          if (valid4) begin
            if (q4.size() == 0) chk("unexpected_valid4", 1, 0);
            else begin
              e = q4.pop_front();
              chk("period4", int'(period4), e.period);
              chk("high4", int'(high4), e.high);
              chk("valid_cycle4", cyc, e.cyc);
            end
          end
        end
      end
    join_none

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_period16", int'(period16), 0);
    chk("rst_high16", int'(high16), 0);
    chk("rst_valid16", int'(valid16), 0);
    chk("rst_ovf16", int'(ovf16), 0);
    chk("rst_period4", int'(period4), 0);
    chk("rst_ovf4", int'(ovf4), 0);
    tick();
    clear = 1'b1;
    tick();

    // Table-driven square waves
    enable16 = 1'b1;
    repeat (2) tick();
    for (int i = 0; i < 16; i++)
      seg16(vecs[i].hi, vecs[i].lo, vecs[i].exp_period, vecs[i].exp_high);

    // Enable dropped mid-period: report of the last table period, then abort
    rise16();
    repeat (6) tick();
    enable16 = 1'b0;
    have16 = 1'b0;
    tick();
    sig16 = 1'b0;
    repeat (2) tick();
    sig16 = 1'b1;
    repeat (2) tick();
    sig16 = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("hold_period16", int'(period16), 10);
    chk("hold_high16", int'(high16), 5);
    chk("hold_ovf16", int'(ovf16), 0);
    tick();
    enable16 = 1'b1;
    repeat (2) tick();
    seg16(6, 6, 12, 6);
    seg16(6, 6, 12, 6);
    seg16(4, 12, 16, 4);
    seg16(4, 12, 16, 4);

    // Clear mid-MEASURE with Period=16 held
    rise16();
    repeat (6) tick();
    @(negedge clk);
    chk("pre_clear_period16", int'(period16), 16);
    tick();
    clear = 1'b0;
    tick();
    @(negedge clk);
    chk("clr_period16", int'(period16), 0);
    chk("clr_high16", int'(high16), 0);
    chk("clr_valid16", int'(valid16), 0);
    chk("clr_ovf16", int'(ovf16), 0);
    tick();
    clear = 1'b1;
    sig16 = 1'b0;
    have16 = 1'b0;
    repeat (2) tick();

    // Clear in the same cycle the second rise would be reported
    seg16(4, 12, 16, 4);
    have16 = 1'b0;
    sig16 = 1'b1;
    repeat (3) tick();
    clear = 1'b0;
    tick();
    @(negedge clk);
    chk("clr_rise_valid16", int'(valid16), 0);
    chk("clr_rise_period16", int'(period16), 0);
    tick();
    clear = 1'b1;
    sig16 = 1'b0;
    repeat (2) tick();

    // After reset release, two rises are needed for a report
    seg16(3, 5, 8, 3);
    seg16(3, 5, 8, 3);
    rise16();
    repeat (2) tick();
    sig16 = 1'b0;
    repeat (8) tick();
    enable16 = 1'b0;
    have16 = 1'b0;
    repeat (2) tick();

    // 4-bit instance: longest reportable period, then overflow
    enable4 = 1'b1;
    repeat (2) tick();
    seg4(8, 7, 15, 8);
    seg4(8, 7, 15, 8);
    c0 = cyc;
    rise4();
    repeat (2) tick();
    sig4 = 1'b0;
    have4 = 1'b0;
    while (cyc < c0 + 18) tick();
    @(negedge clk);
    chk("ovf4_not_yet", int'(ovf4), 0);
    tick();
    @(negedge clk);
    chk("ovf4_set", int'(ovf4), 1);
    chk("ovf4_period_hold", int'(period4), 15);
    tick();

    // Back in ARM: first rise silent, second one reported
    seg4(2, 3, 5, 2);
    seg4(2, 3, 5, 2);
    rise4();
    repeat (2) tick();
    sig4 = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk("ovf4_sticky", int'(ovf4), 1);
    tick();
    enable4 = 1'b0;
    tick();
    @(negedge clk);
    chk("ovf4_cleared", int'(ovf4), 0);
    chk("period4_hold", int'(period4), 5);

    repeat (6) tick();
    chk("pending_valids16", q16.size(), 0);
    chk("pending_valids4", q4.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
